// File: rtl/reg_xfer_sequencer.sv
// reg_xfer_sequencer: splits register-transfer instructions into single-register read/write bus cycles
module reg_xfer_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [DATA_W-1:0] rd_data,
  output logic              rd,
  output logic              wr,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              done,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, RD1, RD2, WR1, WR2, FIN} state_t;
  localparam logic [1:0] NOP = 2'd0, MOV = 2'd1, CLR = 2'd2, SWAP = 2'd3;
  state_t state, nxt;
  logic [1:0] op;
  logic [ADDR_W-1:0] dst, src, addr_c;
  logic [DATA_W-1:0] t0, t1, data_c;
  logic rd_c, wr_c, done_c, accept;
  logic unused_bits;
  assign unused_bits = ^instr[1:0];
  assign accept = instr_valid && instr_ready;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      dst   <= '0;
      src   <= '0;
      t0    <= '0;
      t1    <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        op  <= instr[7:6];
        dst <= ADDR_W'(instr[5:4]);
        src <= ADDR_W'(instr[3:2]);
      end
      if (state == RD1) t0 <= rd_data;
      if (state == RD2) t1 <= rd_data;
    end
  end
  always_comb begin
    nxt    = state;
    rd_c   = 1'b0;
    wr_c   = 1'b0;
    done_c = 1'b0;
    addr_c = '0;
    data_c = '0;
    case (state)
      IDLE: nxt = !accept ? IDLE : instr[7:6] == NOP ? FIN : instr[7:6] == CLR ? WR1 : RD1;
      RD1: begin
        rd_c   = 1'b1;
        addr_c = op == SWAP ? dst : src;
        nxt    = op == SWAP ? RD2 : WR1;
      end
      RD2: begin
        rd_c   = 1'b1;
        addr_c = src;
        nxt    = WR1;
      end
      WR1: begin
        wr_c   = 1'b1;
        addr_c = dst;
        data_c = op == MOV ? t0 : op == SWAP ? t1 : '0;
        done_c = op != SWAP;
        nxt    = op == SWAP ? WR2 : IDLE;
      end
      WR2: begin
        wr_c   = 1'b1;
        addr_c = src;
        data_c = t0;
        done_c = 1'b1;
        nxt    = IDLE;
      end
      FIN: begin
        done_c = 1'b1;
        nxt    = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  // reset masks every output so an aborted instruction emits nothing further
  assign instr_ready = state == IDLE && !rst;
  assign busy        = state != IDLE && !rst;
  assign rd          = rd_c && !rst;
  assign wr          = wr_c && !rst;
  assign done        = done_c && !rst;
  assign reg_addr    = rst ? '0 : addr_c;
  assign wr_data     = rst ? '0 : data_c;
endmodule

// File: tb/tb_reg_xfer_sequencer.sv
// tb_reg_xfer_sequencer: scoreboard bench with a register-file model feeding rd_data
module tb_reg_xfer_sequencer;
  logic clk = 1'b0, rst = 1'b1, instr_valid = 1'b1;
  logic [7:0] instr = 8'h40;
  logic [7:0] rd_data, wr_data;
  logic instr_ready, rd, wr, done, busy, was_done = 1'b0;
  logic [1:0] reg_addr;
  int checks = 0, errors = 0;
  typedef struct packed {logic rd; logic wr; logic [1:0] addr; logic [7:0] data; logic done;} ev_t;
  ev_t q[$];
  logic [7:0] rf [4];
  logic [7:0] m [4];
  logic [7:0] snap [4];

  reg_xfer_sequencer #(.DATA_W(8), .ADDR_W(2)) dut (
    .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .rd_data(rd_data), .rd(rd), .wr(wr), .reg_addr(reg_addr), .wr_data(wr_data),
    .done(done), .busy(busy)
  );

  always #5 clk = ~clk;
  assign rd_data = rf[reg_addr];
  always @(posedge clk) if (wr) rf[reg_addr] <= wr_data;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic ev_t ev(logic r, logic w, logic [1:0] a, logic [7:0] d, logic dn);
    return '{rd: r, wr: w, addr: a, data: d, done: dn};
  endfunction

  task automatic push(input logic [7:0] ins);
    logic [1:0] d, s;
    logic [7:0] x;
    d = ins[5:4];
    s = ins[3:2];
    case (ins[7:6])
      2'd0: q.push_back(ev(0, 0, 0, 0, 1));
      2'd1: begin
        q.push_back(ev(1, 0, s, 0, 0));
        q.push_back(ev(0, 1, d, m[s], 1));
        m[d] = m[s];
      end
      2'd2: begin
        q.push_back(ev(0, 1, d, 0, 1));
        m[d] = 0;
      end
      default: begin
        q.push_back(ev(1, 0, d, 0, 0));
        q.push_back(ev(1, 0, s, 0, 0));
        q.push_back(ev(0, 1, d, m[s], 0));
        q.push_back(ev(0, 1, s, m[d], 1));
        x = m[d];
        m[d] = m[s];
        m[s] = x;
      end
    endcase
  endtask

  // called just after a rising edge; returns just after the accepting edge
  task automatic issue(input logic [7:0] ins, output int waits);
    instr = ins;
    instr_valid = 1'b1;
    waits = 0;
    @(negedge clk);
    while (!instr_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!instr_ready) chk("accept_timeout", 0, 1);
    else push(ins);
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr = 8'($urandom);
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (rst) chk("rst_out", {instr_ready, rd, wr, done, busy, reg_addr, wr_data}, 0);
    else begin
      if (was_done) chk("ready_after_done", instr_ready, 1);
      if (busy) begin
        if (q.size() == 0) chk("spurious_busy", 1, 0);
        else begin
          e = q.pop_front();
          chk("ctl", {instr_ready, rd, wr, reg_addr, done}, {1'b0, e.rd, e.wr, e.addr, e.done});
          if (e.wr) chk("wr_data", wr_data, e.data);
        end
      end else chk("idle_out", {rd, wr, done, instr_ready}, 4'b0001);
    end
    was_done <= done && !rst;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    m = '{8'h11, 8'hA5, 8'h5A, 8'h22};
    rf = m;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    instr_valid = 1'b0;
    @(negedge clk);
    chk("ready_post_rst", instr_ready, 1);
    @(posedge clk);
    #1;
    issue(8'h64, w);
    chk("mov_wait", w, 0);
    issue(8'hB0, w);
    issue(8'hCC, w);
    issue(8'h00, w);
    issue(8'h57, w);
    chk("mov_after_nop_wait", w, 1);
    issue(8'hD7, w);
    snap = m;
    issue(8'hCC, w);
    @(posedge clk);
    #1;
    rst = 1'b1;
    q.delete();
    m = snap;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_idle", {busy, wr, done, instr_ready}, 4'b0001);
    @(posedge clk);
    #1;
    issue(8'h90, w);
    for (int i = 0; i < 10; i++) issue(8'($urandom), w);
    repeat (8) @(negedge clk);
    chk("queue_empty", q.size(), 0);
    for (int i = 0; i < 4; i++) chk($sformatf("rf%0d", i), rf[i], m[i]);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
